// File: rtl/dnn_stream_pkg.sv
// rtl/dnn_stream_pkg.sv - shared types and defaults for the DNN source/destination stream blocks
// Purpose: default widths, the 4x16-bit beat record and the feeder FSM state type.
// Ports: none (package).
package dnn_stream_pkg;

    localparam int AW_DEF = 12;   // memory word-address width
    localparam int LW_DEF = 13;   // transfer length width in beats

    typedef struct packed {
        logic [15:0] d3;
        logic [15:0] d2;
        logic [15:0] d1;
        logic [15:0] d0;
        logic        last;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fsm_t;

    // Splits a 64-bit memory word into lanes, lane 0 taking the low half-word.
    function automatic beat_t make_beat(input logic [63:0] word, input logic last);
        beat_t b;
        b.d0   = word[15:0];
        b.d1   = word[31:16];
        b.d2   = word[47:32];
        b.d3   = word[63:48];
        b.last = last;
        return b;
    endfunction

endpackage

// File: rtl/dnn_beat_fifo2.sv
// rtl/dnn_beat_fifo2.sv - 2-entry registered beat FIFO with push/pop/count
// Purpose: small elastic buffer between a 1-cycle-latency memory and a stream port.
//          The head entry lives in its own register so dout is a clean flop output.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   push, din    write request and beat to store
//   pop          remove the head beat (ignored when empty)
//   dout         head beat (holds while not popped)
//   count        number of stored beats, 0..2
module dnn_beat_fifo2
    import dnn_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  beat_t      din,
    input  logic       pop,
    output beat_t      dout,
    output logic [1:0] count
);

    beat_t      head_q;
    beat_t      tail_q;
    logic [1:0] count_q;
    logic       pop_ok;
    logic       push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    // A full FIFO still accepts a push in the same cycle as a pop.
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= din;
                    else                 tail_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_q <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = head_q;
    assign count = count_q;

endmodule

// File: rtl/dnn_src_feeder.sv
// rtl/dnn_src_feeder.sv - reads len words from local memory and streams them as 4x16-bit beats
// Purpose: host-side sender for the accelerator source port. A start command
//          captures base/len, words are fetched from a 1-cycle-latency memory
//          into a 2-entry FIFO and presented as beats, the final one with src_last.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   start, base, len      command strobe (IDLE only), first word address, beat count
//   busy, done            transfer in progress, one-cycle completion pulse
//   mem_re, mem_addr      memory read request
//   mem_rdata             read data, valid the cycle after mem_re
//   src_valid, src_ready  stream handshake
//   src_data0..3, src_last beat payload and final-beat marker
module dnn_src_feeder
    import dnn_stream_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    input  logic [63:0]   mem_rdata,
    output logic          src_valid,
    output logic [15:0]   src_data0,
    output logic [15:0]   src_data1,
    output logic [15:0]   src_data2,
    output logic [15:0]   src_data3,
    output logic          src_last,
    input  logic          src_ready
);

    fsm_t          state_q;
    fsm_t          state_d;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] reads_left_q;
    logic [LW-1:0] beats_left_q;
    logic          inflight_q;
    logic          inflight_last_q;
    logic          done_q;

    beat_t         head;
    logic [1:0]    fifo_count;
    logic [1:0]    occ;
    logic          handshake;

    assign handshake = src_valid && src_ready;
    // Words already owned by the FIFO path: stored plus the one returning now.
    assign occ       = fifo_count + {1'b0, inflight_q};

    always_comb begin
        state_d = state_q;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) state_d = FETCH;
            end
            FETCH: begin
                // A beat leaving this cycle frees a slot in time for the word
                // returning next cycle, which keeps a 1 beat/cycle stream.
                if ((reads_left_q != '0) && ((occ < 2'd2) || ((occ == 2'd2) && handshake)))
                    mem_re = 1'b1;
                if (mem_re && (reads_left_q == LW'(1))) state_d = FLUSH;
            end
            FLUSH: begin
                if (handshake && src_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            reads_left_q    <= '0;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            done_q          <= 1'b0;
            inflight_q      <= mem_re;
            inflight_last_q <= mem_re && (reads_left_q == LW'(1));
            if ((state_q == IDLE) && start) begin
                if (len == '0) begin
                    done_q <= 1'b1;
                end else begin
                    addr_q       <= base;
                    reads_left_q <= len;
                    beats_left_q <= len;
                end
            end
            if (mem_re) begin
                addr_q       <= addr_q + AW'(1);
                reads_left_q <= reads_left_q - LW'(1);
            end
            if (handshake) beats_left_q <= beats_left_q - LW'(1);
            if ((state_q == FLUSH) && handshake && src_last) done_q <= 1'b1;
        end
    end

    dnn_beat_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (make_beat(mem_rdata, inflight_last_q)),
        .pop   (handshake),
        .dout  (head),
        .count (fifo_count)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign src_valid = (fifo_count != 2'd0);
    assign src_data0 = head.d0;
    assign src_data1 = head.d1;
    assign src_data2 = head.d2;
    assign src_data3 = head.d3;
    assign src_last  = head.last;

    // The last flag carried with the data must agree with the handshake count.
    assert property (@(posedge clk) disable iff (!rst_n)
        src_valid |-> (src_last == (beats_left_q == LW'(1))));

endmodule
